// File: rtl/exe_alu_arb.sv
// Two-requester round-robin arbiter in front of one shared R-type execute unit.
// Also holds exe_rtype, the combinational RV32 R-type unit the arbiter drives.

`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef RDATA_WIDTH
`define RDATA_WIDTH 32
`endif

module exe_rtype #(
  parameter int DW = `DATA_WIDTH,
  parameter int IW = `RDATA_WIDTH
) (
  input  logic [DW-1:0] op1_i,
  input  logic [DW-1:0] op2_i,
  input  logic [IW-1:0] inst_i,
  output logic [IW-1:0] wdata_o,
  output logic          we_o
);
  localparam int SW = (DW > 1) ? $clog2(DW) : 1;

  logic [6:0]    opcode;
  logic [2:0]    funct3;
  logic [6:0]    funct7;
  logic [SW-1:0] shamt;
  logic [DW-1:0] res;
  logic          lt_s;
  logic          lt_u;
  logic          unused_inst;

  assign opcode      = inst_i[6:0];
  assign funct3      = inst_i[14:12];
  assign funct7      = inst_i[31:25];
  assign shamt       = op2_i[SW-1:0];
  assign lt_s        = $signed(op1_i) < $signed(op2_i);
  assign lt_u        = op1_i < op2_i;
  assign unused_inst = ^inst_i;

  // Anything that is not a recognised OP-class encoding yields no write and zero data.
  always_comb begin
    res  = '0;
    we_o = 1'b0;
    if (opcode == 7'b0110011) begin
      case ({funct7, funct3})
        {7'h00, 3'h0}: begin res = op1_i + op2_i;                   we_o = 1'b1; end
        {7'h20, 3'h0}: begin res = op1_i - op2_i;                   we_o = 1'b1; end
        {7'h00, 3'h1}: begin res = op1_i << shamt;                  we_o = 1'b1; end
        {7'h00, 3'h2}: begin res = {{(DW-1){1'b0}}, lt_s};          we_o = 1'b1; end
        {7'h00, 3'h3}: begin res = {{(DW-1){1'b0}}, lt_u};          we_o = 1'b1; end
        {7'h00, 3'h4}: begin res = op1_i ^ op2_i;                   we_o = 1'b1; end
        {7'h00, 3'h5}: begin res = op1_i >> shamt;                  we_o = 1'b1; end
        {7'h20, 3'h5}: begin res = DW'($signed(op1_i) >>> shamt);   we_o = 1'b1; end
        {7'h00, 3'h6}: begin res = op1_i | op2_i;                   we_o = 1'b1; end
        {7'h00, 3'h7}: begin res = op1_i & op2_i;                   we_o = 1'b1; end
        default: begin res = '0; we_o = 1'b0; end
      endcase
    end
  end

  assign wdata_o = IW'(res);
endmodule

module exe_alu_arb #(
  parameter int DW = `DATA_WIDTH,
  parameter int IW = `RDATA_WIDTH
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          req0_valid_i,
  output logic          req0_ready_o,
  input  logic [DW-1:0] req0_op1_i,
  input  logic [DW-1:0] req0_op2_i,
  input  logic [IW-1:0] req0_inst_i,
  input  logic [IW-1:0] req0_waddr_i,
  input  logic          req1_valid_i,
  output logic          req1_ready_o,
  input  logic [DW-1:0] req1_op1_i,
  input  logic [DW-1:0] req1_op2_i,
  input  logic [IW-1:0] req1_inst_i,
  input  logic [IW-1:0] req1_waddr_i,
  output logic [DW-1:0] alu_op1_o,
  output logic [DW-1:0] alu_op2_o,
  output logic [IW-1:0] alu_inst_o,
  input  logic [IW-1:0] alu_wdata_i,
  input  logic          alu_we_i,
  output logic          rsp_valid_o,
  input  logic          rsp_ready_i,
  output logic          rsp_id_o,
  output logic [IW-1:0] rsp_wdata_o,
  output logic [IW-1:0] rsp_waddr_o,
  output logic          rsp_we_o,
  output logic [15:0]   grant_cnt_o
);
  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t        state_q, state_d;
  logic          last_gnt_q, last_gnt_d;
  logic [15:0]   grant_cnt_q, grant_cnt_d;
  logic          rsp_id_q, rsp_id_d;
  logic [IW-1:0] rsp_wdata_q, rsp_wdata_d;
  logic [IW-1:0] rsp_waddr_q, rsp_waddr_d;
  logic          rsp_we_q, rsp_we_d;

  logic          accept_en;
  logic          gnt;
  logic          gnt_id;
  logic [IW-1:0] win_waddr;
  logic [1:0]    req_hit;

  // Grant path: kept apart from the capture logic so the loop through the
  // external execute unit stays between two independent processes.
  always_comb begin
    accept_en = (state_q == IDLE) | ((state_q == HOLD) & rsp_ready_i);
    gnt       = 1'b0;
    gnt_id    = 1'b0;
    if (accept_en && !rst_i) begin
      if (req0_valid_i && req1_valid_i) begin
        gnt    = 1'b1;
        gnt_id = ~last_gnt_q;
      end else if (req0_valid_i) begin
        gnt    = 1'b1;
        gnt_id = 1'b0;
      end else if (req1_valid_i) begin
        gnt    = 1'b1;
        gnt_id = 1'b1;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_hit
      assign req_hit[gi] = gnt & (gnt_id == 1'(gi));
    end
  endgenerate

  assign req0_ready_o = req_hit[0];
  assign req1_ready_o = req_hit[1];
  assign win_waddr    = gnt_id ? req1_waddr_i : req0_waddr_i;

  always_comb begin
    alu_op1_o  = '0;
    alu_op2_o  = '0;
    alu_inst_o = '0;
    if (gnt) begin
      alu_op1_o  = gnt_id ? req1_op1_i  : req0_op1_i;
      alu_op2_o  = gnt_id ? req1_op2_i  : req0_op2_i;
      alu_inst_o = gnt_id ? req1_inst_i : req0_inst_i;
    end
  end

  always_comb begin
    state_d     = state_q;
    last_gnt_d  = last_gnt_q;
    grant_cnt_d = grant_cnt_q;
    rsp_id_d    = rsp_id_q;
    rsp_wdata_d = rsp_wdata_q;
    rsp_waddr_d = rsp_waddr_q;
    rsp_we_d    = rsp_we_q;
    if (gnt) begin
      state_d     = HOLD;
      last_gnt_d  = gnt_id;
      grant_cnt_d = grant_cnt_q + 16'd1;
      rsp_id_d    = gnt_id;
      rsp_wdata_d = alu_wdata_i;
      rsp_waddr_d = win_waddr;
      rsp_we_d    = alu_we_i & (win_waddr != '0);
    end else if ((state_q == HOLD) && rsp_ready_i) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // last_gnt resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_gnt_q  <= 1'b1;
      grant_cnt_q <= '0;
      rsp_id_q    <= 1'b0;
      rsp_wdata_q <= '0;
      rsp_waddr_q <= '0;
      rsp_we_q    <= 1'b0;
    end else begin
      last_gnt_q  <= last_gnt_d;
      grant_cnt_q <= grant_cnt_d;
      rsp_id_q    <= rsp_id_d;
      rsp_wdata_q <= rsp_wdata_d;
      rsp_waddr_q <= rsp_waddr_d;
      rsp_we_q    <= rsp_we_d;
    end
  end

  assign rsp_valid_o = (state_q == HOLD);
  assign rsp_id_o    = rsp_id_q;
  assign rsp_wdata_o = rsp_wdata_q;
  assign rsp_waddr_o = rsp_waddr_q;
  assign rsp_we_o    = rsp_we_q;
  assign grant_cnt_o = grant_cnt_q;
endmodule

// File: tb/tb_exe_alu_arb.sv
// Bench for exe_alu_arb wired to exe_rtype; directed scenarios plus a random
// run checked against a transaction-level model of arbitration and RV32 R-type results.
module tb_exe_alu_arb;
  logic clk = 1'b0;
  logic rst;
  logic v0, v1, rsp_ready;
  logic [31:0] a0, b0, inst0, wa0, a1, b1, inst1, wa1;
  logic rdy0, rdy1;
  logic [31:0] alu_op1, alu_op2, alu_inst, alu_wdata;
  logic alu_we;
  logic rsp_valid, rsp_id, rsp_we;
  logic [31:0] rsp_wdata, rsp_waddr;
  logic [15:0] grant_cnt;

  int checks = 0;
  int errors = 0;
  bit quiet = 0;

  bit          m_hold, m_id, m_we, m_last;
  logic [31:0] m_wdata, m_waddr;
  logic [15:0] m_cnt;

  always #5 clk = ~clk;

  exe_alu_arb #(.DW(32), .IW(32)) dut (
    .clk_i(clk), .rst_i(rst),
    .req0_valid_i(v0), .req0_ready_o(rdy0), .req0_op1_i(a0), .req0_op2_i(b0),
    .req0_inst_i(inst0), .req0_waddr_i(wa0),
    .req1_valid_i(v1), .req1_ready_o(rdy1), .req1_op1_i(a1), .req1_op2_i(b1),
    .req1_inst_i(inst1), .req1_waddr_i(wa1),
    .alu_op1_o(alu_op1), .alu_op2_o(alu_op2), .alu_inst_o(alu_inst),
    .alu_wdata_i(alu_wdata), .alu_we_i(alu_we),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_id_o(rsp_id),
    .rsp_wdata_o(rsp_wdata), .rsp_waddr_o(rsp_waddr), .rsp_we_o(rsp_we),
    .grant_cnt_o(grant_cnt)
  );

  exe_rtype #(.DW(32), .IW(32)) u_exe (
    .op1_i(alu_op1), .op2_i(alu_op2), .inst_i(alu_inst),
    .wdata_o(alu_wdata), .we_o(alu_we)
  );

  // RV32I OP-class semantics: returns {write_enable, result}.
  function automatic logic [32:0] ref_alu(input logic [31:0] inst, input logic [31:0] a, input logic [31:0] b);
    logic [6:0] f7;
    logic [31:0] r;
    bit ok;
    f7 = inst[31:25];
    r = 32'h0;
    ok = 1;
    if (inst[6:0] != 7'b0110011) return 33'h0;
    case (inst[14:12])
      3'd0: if (f7 == 7'h00) r = a + b; else if (f7 == 7'h20) r = a - b; else ok = 0;
      3'd1: begin r = a << b[4:0]; ok = (f7 == 7'h00); end
      3'd2: begin r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; ok = (f7 == 7'h00); end
      3'd3: begin r = (a < b) ? 32'd1 : 32'd0; ok = (f7 == 7'h00); end
      3'd4: begin r = a ^ b; ok = (f7 == 7'h00); end
      3'd5: if (f7 == 7'h00) r = a >> b[4:0]; else if (f7 == 7'h20) r = 32'($signed(a) >>> b[4:0]); else ok = 0;
      3'd6: begin r = a | b; ok = (f7 == 7'h00); end
      default: begin r = a & b; ok = (f7 == 7'h00); end
    endcase
    if (!ok) return 33'h0;
    return {1'b1, r};
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [6:0] f7;
    logic [2:0] f3;
    logic [6:0] opc;
    int k;
    k = $urandom_range(0, 11);
    opc = 7'b0110011;
    f3 = 3'(k);
    f7 = 7'h00;
    case (k)
      8: begin f3 = 3'd0; f7 = 7'h20; end
      9: begin f3 = 3'd5; f7 = 7'h20; end
      10: begin opc = 7'b0010011; f3 = 3'($urandom); f7 = 7'($urandom); end
      11: begin f3 = 3'($urandom); f7 = 7'h01; end
      default: ;
    endcase
    return {f7, 5'($urandom), 5'($urandom), f3, 5'($urandom), opc};
  endfunction

  function automatic void model_grant(output bit g, output bit id);
    g = 0;
    id = 0;
    if (rst || (m_hold && !rsp_ready)) return;
    if (v0 && v1) begin g = 1; id = (m_last == 1'b0); end
    else if (v0) begin g = 1; id = 0; end
    else if (v1) begin g = 1; id = 1; end
  endfunction

  function automatic void model_reset();
    m_hold = 0; m_id = 0; m_we = 0; m_last = 1; m_wdata = 0; m_waddr = 0; m_cnt = 0;
  endfunction

  // Advance the model by one edge using the inputs currently applied, then clock the DUT.
  task automatic step();
    bit g, id;
    logic [32:0] r;
    logic [31:0] wa;
    model_grant(g, id);
    if (g) begin
      r = id ? ref_alu(inst1, a1, b1) : ref_alu(inst0, a0, b0);
      wa = id ? wa1 : wa0;
      m_hold = 1; m_id = id; m_wdata = r[31:0]; m_waddr = wa;
      m_we = r[32] && (wa != 0); m_last = id; m_cnt = m_cnt + 16'd1;
      if (!quiet) $display("grant id=%0d inst=%h wdata=%h waddr=%0d we=%0d cnt=%0d", id, id ? inst1 : inst0, m_wdata, m_waddr, m_we, m_cnt);
    end else if (m_hold && rsp_ready) begin
      m_hold = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    v0 = 0; v1 = 0; rsp_ready = 1;
    a0 = 0; b0 = 0; inst0 = 0; wa0 = 0; a1 = 0; b1 = 0; inst1 = 0; wa1 = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    idle_inputs();
    v0 = 1; v1 = 1; a0 = 32'h11; b0 = 32'h22; inst0 = 32'h002080B3; a1 = 32'h33; inst1 = 32'h002080B3;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    checks++; if (rdy0 !== 1'b0 || rdy1 !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b%b expected 00", rdy0, rdy1); end
    checks++; if (alu_op1 !== 0 || alu_op2 !== 0 || alu_inst !== 0) begin errors++; $display("FAIL reset_alu: got %h %h %h expected 0 0 0", alu_op1, alu_op2, alu_inst); end
    checks++; if (rsp_valid !== 1'b0 || rsp_we !== 1'b0 || rsp_id !== 1'b0) begin errors++; $display("FAIL reset_rsp_ctl: got v=%b we=%b id=%b expected 0 0 0", rsp_valid, rsp_we, rsp_id); end
    checks++; if (rsp_wdata !== 0 || rsp_waddr !== 0 || grant_cnt !== 0) begin errors++; $display("FAIL reset_rsp_data: got %h %h cnt=%h expected 0 0 0", rsp_wdata, rsp_waddr, grant_cnt); end
    idle_inputs();
    rst = 0;
    step();
    checks++; if (rsp_valid !== 1'b0 || grant_cnt !== 16'd0) begin errors++; $display("FAIL reset_release: got v=%b cnt=%0d expected 0 0", rsp_valid, grant_cnt); end
    $display("reset done");
  endtask

  task automatic test_tie();
    logic [32:0] r;
    bit exp_id;
    v0 = 1; v1 = 1; rsp_ready = 1;
    for (int i = 0; i < 4; i++) begin
      a0 = $urandom; b0 = $urandom; inst0 = rand_inst(); wa0 = 32'($urandom_range(1, 31));
      a1 = $urandom; b1 = $urandom; inst1 = rand_inst(); wa1 = 32'($urandom_range(1, 31));
      exp_id = (i % 2) == 1;
      r = exp_id ? ref_alu(inst1, a1, b1) : ref_alu(inst0, a0, b0);
      #1;
      checks++; if (rdy0 !== !exp_id || rdy1 !== exp_id) begin errors++; $display("FAIL tie_ready[%0d]: got %b%b expected %b%b", i, rdy1, rdy0, exp_id, !exp_id); end
      checks++; if (alu_op1 !== (exp_id ? a1 : a0)) begin errors++; $display("FAIL tie_alu_op1[%0d]: got %h expected %h", i, alu_op1, exp_id ? a1 : a0); end
      step();
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== exp_id) begin errors++; $display("FAIL tie_rsp[%0d]: got v=%b id=%b expected 1 %b", i, rsp_valid, rsp_id, exp_id); end
      checks++; if (rsp_wdata !== r[31:0]) begin errors++; $display("FAIL tie_wdata[%0d]: got %h expected %h", i, rsp_wdata, r[31:0]); end
    end
    checks++; if (grant_cnt !== 16'd4) begin errors++; $display("FAIL tie_count: got %0d expected 4", grant_cnt); end
    idle_inputs();
    step();
  endtask

  task automatic test_single();
    idle_inputs();
    v0 = 1; inst0 = 32'h002080B3; a0 = 5; b0 = 7; wa0 = 1;
    #1;
    checks++; if (rdy0 !== 1'b1 || rdy1 !== 1'b0) begin errors++; $display("FAIL single_ready: got %b%b expected 01", rdy1, rdy0); end
    checks++; if (alu_op1 !== 32'd5 || alu_op2 !== 32'd7 || alu_inst !== 32'h002080B3) begin errors++; $display("FAIL single_alu: got %h %h %h expected 5 7 002080b3", alu_op1, alu_op2, alu_inst); end
    step();
    v0 = 0;
    checks++; if (rsp_valid !== 1'b1 || rsp_wdata !== 32'd12 || rsp_waddr !== 32'd1) begin errors++; $display("FAIL single_rsp: got v=%b wdata=%0d waddr=%0d expected 1 12 1", rsp_valid, rsp_wdata, rsp_waddr); end
    checks++; if (rsp_we !== 1'b1 || rsp_id !== 1'b0) begin errors++; $display("FAIL single_we_id: got we=%b id=%b expected 1 0", rsp_we, rsp_id); end
    step();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_drain: got v=%b expected 0", rsp_valid); end
  endtask

  task automatic test_backpressure();
    logic [32:0] r1;
    idle_inputs();
    v0 = 1; inst0 = 32'h40208133; a0 = 100; b0 = 58; wa0 = 2;
    step();
    v0 = 0; v1 = 1; rsp_ready = 0;
    inst1 = 32'h0020E1B3; a1 = 32'hF0; b1 = 32'h0F; wa1 = 3;
    r1 = ref_alu(inst1, a1, b1);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (rdy1 !== 1'b0 || alu_inst !== 0) begin errors++; $display("FAIL bp_stall_ready[%0d]: got rdy1=%b inst=%h expected 0 0", i, rdy1, alu_inst); end
      step();
      checks++; if (rsp_valid !== 1'b1 || rsp_wdata !== 32'd42 || rsp_waddr !== 32'd2 || rsp_id !== 1'b0) begin errors++; $display("FAIL bp_stable[%0d]: got v=%b %0d %0d id=%b expected 1 42 2 0", i, rsp_valid, rsp_wdata, rsp_waddr, rsp_id); end
    end
    rsp_ready = 1;
    #1;
    checks++; if (rdy1 !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b expected 1", rdy1); end
    step();
    v1 = 0;
    checks++; if (rsp_id !== 1'b1 || rsp_wdata !== r1[31:0] || rsp_waddr !== 32'd3) begin errors++; $display("FAIL bp_second: got id=%b %h %0d expected 1 %h 3", rsp_id, rsp_wdata, rsp_waddr, r1[31:0]); end
    step();
  endtask

  task automatic test_x0_nonr();
    idle_inputs();
    v0 = 1; inst0 = 32'h00208033; a0 = 3; b0 = 4; wa0 = 0;
    step();
    checks++; if (rsp_valid !== 1'b1 || rsp_we !== 1'b0 || rsp_wdata !== 32'd7) begin errors++; $display("FAIL x0_write: got v=%b we=%b wdata=%0d expected 1 0 7", rsp_valid, rsp_we, rsp_wdata); end
    inst0 = 32'h00508093; a0 = 9; b0 = 9; wa0 = 1;
    step();
    v0 = 0;
    checks++; if (rsp_valid !== 1'b1 || rsp_we !== 1'b0 || rsp_wdata !== 32'd0) begin errors++; $display("FAIL nonr: got v=%b we=%b wdata=%h expected 1 0 0", rsp_valid, rsp_we, rsp_wdata); end
    step();
  endtask

  task automatic test_random();
    bit g, id;
    for (int i = 0; i < 300; i++) begin
      v0 = ($urandom_range(0, 3) != 0); v1 = ($urandom_range(0, 2) != 0);
      rsp_ready = ($urandom_range(0, 3) != 0);
      a0 = $urandom; b0 = $urandom; inst0 = rand_inst(); wa0 = 32'($urandom_range(0, 3));
      a1 = $urandom; b1 = $urandom; inst1 = rand_inst(); wa1 = 32'($urandom_range(0, 3));
      #1;
      model_grant(g, id);
      checks++; if (rdy0 !== (g && !id) || rdy1 !== (g && id)) begin errors++; $display("FAIL rnd_ready[%0d]: got %b%b expected %b%b", i, rdy1, rdy0, g && id, g && !id); end
      checks++; if (alu_inst !== (g ? (id ? inst1 : inst0) : 32'h0) || alu_op2 !== (g ? (id ? b1 : b0) : 32'h0)) begin errors++; $display("FAIL rnd_alu[%0d]: got inst=%h op2=%h", i, alu_inst, alu_op2); end
      step();
      checks++; if (rsp_valid !== m_hold || grant_cnt !== m_cnt) begin errors++; $display("FAIL rnd_state[%0d]: got v=%b cnt=%0d expected %b %0d", i, rsp_valid, grant_cnt, m_hold, m_cnt); end
      if (m_hold) begin
        checks++; if (rsp_id !== m_id || rsp_wdata !== m_wdata || rsp_waddr !== m_waddr || rsp_we !== m_we) begin errors++; $display("FAIL rnd_rsp[%0d]: got id=%b %h %0d we=%b expected %b %h %0d %b", i, rsp_id, rsp_wdata, rsp_waddr, rsp_we, m_id, m_wdata, m_waddr, m_we); end
      end
    end
    idle_inputs();
    step();
  endtask

  task automatic test_reset_mid_hold();
    idle_inputs();
    v0 = 1; inst0 = 32'h002080B3; a0 = 1; b0 = 2; wa0 = 5;
    step();
    v0 = 0; rsp_ready = 0;
    #2 rst = 1;
    model_reset();
    #1;
    checks++; if (rsp_valid !== 1'b0 || grant_cnt !== 16'd0 || rsp_we !== 1'b0) begin errors++; $display("FAIL midrst_clear: got v=%b cnt=%0d we=%b expected 0 0 0", rsp_valid, grant_cnt, rsp_we); end
    @(posedge clk); #1;
    rst = 0;
    v0 = 1; v1 = 1; rsp_ready = 1; inst1 = 32'h002080B3; a1 = 8; b1 = 8; wa1 = 6;
    #1;
    checks++; if (rdy0 !== 1'b1 || rdy1 !== 1'b0) begin errors++; $display("FAIL midrst_first: got %b%b expected 01", rdy1, rdy0); end
    step();
    checks++; if (rsp_id !== 1'b0 || grant_cnt !== 16'd1 || rsp_wdata !== 32'd3) begin errors++; $display("FAIL midrst_rsp: got id=%b cnt=%0d wdata=%0d expected 0 1 3", rsp_id, grant_cnt, rsp_wdata); end
    idle_inputs();
    step();
  endtask

  task automatic test_wrap();
    idle_inputs();
    v0 = 1; inst0 = 32'h002080B3; a0 = 1; b0 = 1; wa0 = 1;
    quiet = 1;
    for (int k = 0; k < 70000 && m_cnt != 16'hFFFF; k++) step();
    quiet = 0;
    $display("preloaded grant count to %0d", m_cnt);
    checks++; if (grant_cnt !== 16'hFFFF) begin errors++; $display("FAIL wrap_preload: got %h expected ffff", grant_cnt); end
    step();
    checks++; if (grant_cnt !== 16'h0000 || rsp_valid !== 1'b1) begin errors++; $display("FAIL wrap_zero: got cnt=%h v=%b expected 0000 1", grant_cnt, rsp_valid); end
    idle_inputs();
    step();
  endtask

  initial begin
    test_reset();
    test_tie();
    test_single();
    test_backpressure();
    test_x0_nonr();
    test_random();
    test_reset_mid_hold();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
